cmd_stream_controller: RTL and testbench

- Parametrised successor to the coprocessor's word-serial register controller.
- Accepts a stream of WORD_W-bit command words over a valid/ready handshake. A header word selects a register and a direction, then payload beats are moved between the narrow command/response ports and the BUS_W-wide register bank of the main datapath.
- Adds what the previous generation lacked: backpressure on both sides, an explicit last-beat marker, a read snapshot, a per-register beat-count table, and no partial commits.

---
 rtl/cmd_stream_pkg.sv | 26 ++
 rtl/cmd_stream_controller.sv | 164 ++++++++++++++++
 tb/tb_cmd_stream_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_stream_pkg.sv
// Shared types and constants for the command-stream register controller:
// FSM states, header field positions and the per-register beat-count table.
package cmd_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_SNAP,
    RD_SEND,
    WR_DATA,
    COMMIT
  } state_e;

  // Header fields are located relative to the MSB of the command word.
  localparam int HDR_DIR_FROM_MSB = 0;
  localparam int HDR_SEL_FROM_MSB = 1;

  function automatic int unsigned beat_count(input int unsigned sel);
    case (sel)
      0, 1, 2, 4, 8, 9: return 4;
      5, 6:             return 8;
      12, 13, 14:       return 5;
      default:          return 1;
    endcase
  endfunction

endpackage

// File: rtl/cmd_stream_controller.sv
// Moves register contents between a narrow valid/ready command/response stream
// and a wide datapath register bank; writes commit atomically, reads use a snapshot.
module cmd_stream_controller
  import cmd_stream_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BUS_W    = 256,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WORD_W-1:0]   cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic [SEL_W-1:0]    select_read,
  output logic [NUM_REGS-1:0] write_enable,
  output logic [BUS_W-1:0]    write_bus,
  input  logic [BUS_W-1:0]    data_out
);

  localparam int BEATS = BUS_W / WORD_W;
  localparam int CNT_W = $clog2(BEATS) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [BUS_W-1:0]    snap_q, snap_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_last_q, rsp_last_d;
  logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
  logic [SEL_W-1:0]    select_read_q, select_read_d;
  logic [NUM_REGS-1:0] write_enable_q, write_enable_d;
  logic [BUS_W-1:0]    write_bus_q, write_bus_d;

  logic                cmd_fire;
  logic                rsp_fire;
  logic                hdr_dir;
  logic [SEL_W-1:0]    hdr_sel;
  logic [CNT_W-1:0]    cnt_nxt;
  int unsigned         hdr_beats;

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;
  assign hdr_dir  = cmd_data[WORD_W-1-HDR_DIR_FROM_MSB];
  assign hdr_sel  = cmd_data[WORD_W-1-HDR_SEL_FROM_MSB -: SEL_W];
  assign cnt_nxt  = cnt_q + CNT_W'(1);

  always_comb begin
    hdr_beats = beat_count(32'(hdr_sel));
    if (hdr_beats > BEATS) hdr_beats = BEATS;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    beats_d        = beats_q;
    snap_d         = snap_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_last_d     = rsp_last_q;
    rsp_data_d     = rsp_data_q;
    select_read_d  = select_read_q;
    write_enable_d = '0;
    write_bus_d    = write_bus_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          select_read_d = hdr_sel;
          beats_d       = CNT_W'(hdr_beats);
          cnt_d         = '0;
          if (hdr_dir) begin
            write_bus_d = '0;
            state_d     = WR_DATA;
          end else begin
            state_d = RD_SNAP;
          end
        end
      end
      RD_SNAP: begin
        // select_read has been registered for a cycle, so data_out is settled here.
        snap_d      = data_out;
        rsp_valid_d = 1'b1;
        rsp_data_d  = data_out[WORD_W-1:0];
        rsp_last_d  = (beats_q == CNT_W'(1));
        state_d     = RD_SEND;
      end
      RD_SEND: begin
        if (rsp_fire) begin
          if (rsp_last_q) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d      = cnt_nxt;
            rsp_data_d = snap_q[WORD_W*int'(cnt_nxt) +: WORD_W];
            rsp_last_d = (cnt_nxt == beats_q - CNT_W'(1));
          end
        end
      end
      WR_DATA: begin
        if (cmd_fire) begin
          write_bus_d[WORD_W*int'(cnt_q) +: WORD_W] = cmd_data;
          cnt_d = cnt_nxt;
          if (cnt_nxt == beats_q) begin
            write_enable_d = NUM_REGS'(1) << select_read_q;
            state_d        = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered ready follows the state being entered, so it always matches state_q.
    cmd_ready_d = (state_d == IDLE) || (state_d == WR_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      beats_q        <= '0;
      snap_q         <= '0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_last_q     <= 1'b0;
      rsp_data_q     <= '0;
      select_read_q  <= '0;
      write_enable_q <= '0;
      write_bus_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      beats_q        <= beats_d;
      snap_q         <= snap_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_last_q     <= rsp_last_d;
      rsp_data_q     <= rsp_data_d;
      select_read_q  <= select_read_d;
      write_enable_q <= write_enable_d;
      write_bus_q    <= write_bus_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_last     = rsp_last_q;
  assign rsp_data     = rsp_data_q;
  assign select_read  = select_read_q;
  assign write_enable = write_enable_q;
  assign write_bus    = write_bus_q;

endmodule

// File: tb/tb_cmd_stream_controller.sv
// Scoreboard bench for cmd_stream_controller: stimulus queues expected responses
// and commits, a negedge monitor pops and compares them as the DUT emits.
module tb_cmd_stream_controller;

  logic         clock;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_last;
  logic [3:0]   select_read;
  logic [15:0]  write_enable;
  logic [255:0] write_bus;
  logic [255:0] data_out;

  cmd_stream_controller #(
    .WORD_W(32), .BUS_W(256), .NUM_REGS(16), .SEL_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .select_read(select_read), .write_enable(write_enable), .write_bus(write_bus),
    .data_out(data_out)
  );

  typedef struct { logic [31:0] data; logic last; } rsp_t;
  typedef struct { logic [15:0] we; logic [255:0] bus; } wr_t;

  rsp_t exp_rsp_q[$];
  wr_t  exp_wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_rise_cyc  = -1;
  int last_beat_cyc = -1;
  int we_cyc        = -1;
  logic rsp_v_prev  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [31:0] hdr(input bit dir, input int sel);
    logic [3:0] s;
    s = 4'(sel);
    return {dir, s, 27'd0};
  endfunction

  // Monitor: pops expected beats/commits whenever the DUT presents them.
  always @(negedge clock) begin
    rsp_t e;
    wr_t  w;
    if (rsp_valid && !rsp_v_prev) rsp_rise_cyc = cyc;
    rsp_v_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_unexpected: got beat %h last=%0b, expected none", rsp_data, rsp_last);
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp_data", 256'(rsp_data), 256'(e.data));
        check("rsp_last", 256'(rsp_last), 256'(e.last));
      end
      if (rsp_last) last_beat_cyc = cyc;
    end
    if (write_enable != 16'h0) begin
      we_cyc = cyc;
      if (exp_wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL we_unexpected: got write_enable %h, expected 0", write_enable);
      end else begin
        w = exp_wr_q.pop_front();
        check("write_enable", 256'(write_enable), 256'(w.we));
        check("write_bus", write_bus, w.bus);
      end
    end
  end

  task automatic send(input logic [31:0] d, output int acc);
    bit ok;
    ok = 0;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok  = 1;
        acc = cyc;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for word %h, expected 1", d);
    end else begin
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_rsp_q.size() == 0 && exp_wr_q.size() == 0) break;
      @(posedge clock);
    end
    if (exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: %0d beats and %0d commits outstanding, expected 0",
               name, exp_rsp_q.size(), exp_wr_q.size());
      exp_rsp_q.delete();
      exp_wr_q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int h;
    int dummy;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    data_out  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", 256'(cmd_ready), 256'd0);
    check("rst_rsp_valid", 256'(rsp_valid), 256'd0);
    check("rst_write_enable", 256'(write_enable), 256'd0);
    check("rst_write_bus", write_bus, 256'd0);
    check("rst_select_read", 256'(select_read), 256'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Write sel=5 (8 beats), valid held high.
    exp_wr_q.push_back('{16'h0020,
      256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111});
    send(hdr(1, 5), h);
    for (int k = 1; k <= 8; k++) send(32'h11111111 * k, dummy);
    drain("wr5");
    check("wr5_latency", 256'(we_cyc - h), 256'd9);

    // Read sel=12 (5 beats), consumer always ready.
    data_out = 256'h00000000_00000000_00000000_00000005_00000004_00000003_00000002_00000001;
    for (int k = 1; k <= 5; k++) exp_rsp_q.push_back('{32'(k), k == 5});
    send(hdr(0, 12), h);
    drain("rd12");
    check("rd12_latency", 256'(rsp_rise_cyc - h), 256'd2);
    check("rd12_b2b", 256'(last_beat_cyc - rsp_rise_cyc), 256'd4);

    // Read sel=3 (1 beat) under backpressure; reserved header bits set.
    rsp_ready = 1'b0;
    data_out  = {{7{32'h5A5A5A5A}}, 32'hDEADBEEF};
    exp_rsp_q.push_back('{32'hDEADBEEF, 1'b1});
    send(hdr(0, 3) | 32'h00123456, h);
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      @(negedge clock);
    end
    for (int k = 0; k < 4; k++) begin
      check("rd3_hold_data", 256'(rsp_data), 256'h0DEADBEEF);
      check("rd3_hold_last", 256'(rsp_last), 256'd1);
      @(negedge clock);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rd3_valid_drop", 256'(rsp_valid), 256'd0);
    check("rd3_idle_ready", 256'(cmd_ready), 256'd1);
    drain("rd3");

    // Write sel=0 with cmd_valid toggling every cycle.
    exp_wr_q.push_back('{16'h0001,
      256'h00000000_00000000_00000000_00000000_A3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0});
    send(hdr(1, 0), h);
    for (int k = 0; k < 4; k++) begin
      cmd_data = 32'hBAD0BAD0;
      @(posedge clock); #1;
      send(32'hA0A0A0A0 + 32'h01010101 * k, dummy);
    end
    cmd_data = 32'hBAD0BAD0;
    drain("wr0");

    // Reset in the middle of a write sel=1; nothing may commit.
    send(hdr(1, 1), h);
    send(32'hC0C0C0C0, dummy);
    send(32'hC1C1C1C1, dummy);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_cmd_ready", 256'(cmd_ready), 256'd0);
    check("mid_rst_rsp_valid", 256'(rsp_valid), 256'd0);
    check("mid_rst_rsp_last", 256'(rsp_last), 256'd0);
    check("mid_rst_rsp_data", 256'(rsp_data), 256'd0);
    check("mid_rst_select_read", 256'(select_read), 256'd0);
    check("mid_rst_write_enable", 256'(write_enable), 256'd0);
    check("mid_rst_write_bus", write_bus, 256'd0);
    data_out = {128'h0, 128'h00000043_00000042_00000041_00000040};
    for (int k = 0; k < 4; k++) exp_rsp_q.push_back('{32'h40 + 32'(k), k == 3});
    send(hdr(0, 4), h);
    drain("rd4");

    // Read sel=6: data_out changes after the snapshot is taken.
    data_out = 256'h60000007_60000006_60000005_60000004_60000003_60000002_60000001_60000000;
    for (int k = 0; k < 8; k++) exp_rsp_q.push_back('{32'h60000000 + 32'(k), k == 7});
    send(hdr(0, 6), h);
    @(posedge clock); #1;
    data_out = {8{32'hCAFEF00D}};
    drain("rd6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
